// File: rtl/serial_twos_complement.sv
// serial_twos_complement: bit-serial LSB-first two's/one's complementer with valid/ready handshakes
module serial_twos_complement #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d, seen_q, seen_d, ovf_q, ovf_d;
    logic             b, r, last;
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
        end
    end
    // next state: capture in IDLE, one bit per edge in SHIFT, hold result in DONE
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        seen_d    = seen_q;
        ovf_d     = ovf_q;
        in_ready  = (state_q == IDLE) & ~rst;
        out_valid = state_q == DONE;
        b         = sh_q[0];
        r         = (mode_q | seen_q) ? ~b : b;
        last      = cnt_q == CW'(WIDTH - 1);
        case (state_q)
            IDLE: if (in_valid & in_ready) begin
                sh_d    = in_data;
                mode_d  = in_mode;
                cnt_d   = '0;
                seen_d  = 1'b0;
                ovf_d   = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sh_d   = sh_q >> 1;
                res_d  = {r, res_q[WIDTH-1:1]};
                seen_d = seen_q | b;
                cnt_d  = last ? cnt_q : cnt_q + 1'b1;
                if (last) begin
                    // most-negative operand: all lower bits zero and the MSB set
                    ovf_d   = ~mode_q & ~seen_q & b;
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign out_data = res_q;
    assign out_ovf  = ovf_q;
endmodule

// File: tb/tb_serial_twos_complement.sv
// tb_serial_twos_complement: directed checks of the 8-bit and 4-bit serial complementer
module tb_serial_twos_complement;
    logic       clk = 1'b0;
    logic       rst;
    logic       i8_valid, i8_ready, i8_mode, o8_valid, o8_ready, o8_ovf;
    logic [7:0] i8_data, o8_data;
    logic       i4_valid, i4_ready, i4_mode, o4_valid, o4_ready, o4_ovf;
    logic [3:0] i4_data, o4_data;
    int         checks = 0;
    int         failures = 0;
    int         hs4 = 0;
    always #5 clk = ~clk;
    serial_twos_complement #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(i8_valid), .in_ready(i8_ready), .in_data(i8_data),
        .in_mode(i8_mode), .out_valid(o8_valid), .out_ready(o8_ready), .out_data(o8_data),
        .out_ovf(o8_ovf)
    );
    serial_twos_complement #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(i4_valid), .in_ready(i4_ready), .in_data(i4_data),
        .in_mode(i4_mode), .out_valid(o4_valid), .out_ready(o4_ready), .out_data(o4_data),
        .out_ovf(o4_ovf)
    );
    always @(posedge clk) if (o4_valid && o4_ready) hs4++;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // one 8-bit transaction starting at a negedge with the DUT idle; ends at a negedge, idle
    task automatic run8(input logic [7:0] d, input logic m, input int hold,
                        input logic [7:0] ed, input logic eo, input string tag);
        int n;
        i8_valid = 1'b1;
        i8_data  = d;
        i8_mode  = m;
        o8_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        i8_valid = 1'b0;
        i8_mode  = ~m;
        n = 1;
        while (!o8_valid && n < 20) begin
            if (n == 3) i8_data = ~d;
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n - 1, 8);
        check({tag, "_data"}, o8_data, ed);
        check({tag, "_ovf"}, o8_ovf, eo);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, "_hold_v"}, o8_valid, 1);
                check({tag, "_hold_d"}, o8_data, ed);
                check({tag, "_hold_o"}, o8_ovf, eo);
                check({tag, "_hold_rdy"}, i8_ready, 0);
            end
            o8_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_vlow"}, o8_valid, 0);
        check({tag, "_rdy"}, i8_ready, 1);
    endtask
    initial begin
        int n;
        logic [3:0] e;
        rst = 1'b1;
        {i8_valid, i8_mode, o8_ready, i4_valid, i4_mode, o4_ready} = '0;
        i8_data = '0;
        i4_data = '0;
        repeat (2) @(negedge clk);
        check("rst_v", o8_valid, 0);
        check("rst_d", o8_data, 0);
        check("rst_o", o8_ovf, 0);
        check("rst_rdy", i8_ready, 0);
        rst = 1'b0;
        #1 check("rdy_after_rst", i8_ready, 1);
        @(negedge clk);
        run8(8'h05, 1'b0, 0, 8'hFB, 1'b0, "t05");
        run8(8'h00, 1'b0, 0, 8'h00, 1'b0, "t00");
        run8(8'h80, 1'b0, 0, 8'h80, 1'b1, "t80");
        run8(8'hFF, 1'b0, 0, 8'h01, 1'b0, "tFF");
        run8(8'h01, 1'b0, 0, 8'hFF, 1'b0, "t01");
        run8(8'h5A, 1'b1, 0, 8'hA5, 1'b0, "t5A_m1");
        run8(8'h5A, 1'b0, 0, 8'hA6, 1'b0, "t5A_m0");
        run8(8'h80, 1'b1, 0, 8'h7F, 1'b0, "t80_m1");
        run8(8'h3C, 1'b0, 10, 8'hC4, 1'b0, "bp");
        i8_valid = 1'b1;
        i8_data  = 8'h33;
        i8_mode  = 1'b0;
        o8_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i8_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 check("mid_rst_rdy", i8_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_v", o8_valid, 0);
        check("mid_rst_d", o8_data, 0);
        check("mid_rst_o", o8_ovf, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (o8_valid) n++;
            @(negedge clk);
        end
        check("mid_rst_nopulse", n, 0);
        run8(8'h10, 1'b0, 0, 8'hF0, 1'b0, "t10");
        for (int i = 0; i < 16; i++) begin
            e = 4'(0 - i);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            i4_valid = 1'b1;
            i4_data  = 4'(i);
            @(posedge clk);
            @(negedge clk);
            i4_valid = 1'b0;
            n = 0;
            while (!o4_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("w4_%0d_to", i), n < 20, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check($sformatf("w4_%0d_d", i), o4_data, e);
            check($sformatf("w4_%0d_o", i), o4_ovf, i == 8);
            o4_ready = 1'b1;
            @(negedge clk);
            o4_ready = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("w4_count", hs4, 16);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
